// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: frames latched bytes as start, LSB-first data,
// optional parity and stop bits, advancing one bit per tick_baud strobe.
module uart_tx_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_baud,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);

    // state  | meaning
    // IDLE   | line high, waiting for a pending byte and a tick
    // START  | start bit (low) on the line
    // DATA   | data bits, LSB first, bit_cnt = index of bit on the line
    // PARITY | parity bit on the line
    // STOP   | stop bit(s) high, stop_cnt = index of stop bit on the line
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
    logic [3:0]           r_bit_cnt, w_bit_cnt_nxt;
    logic                 r_stop_cnt, w_stop_cnt_nxt;
    logic                 r_pending, w_pending_nxt;
    logic                 r_parity, w_parity_nxt;
    logic                 r_tx, w_tx_nxt;
    logic                 w_last_stop;
    logic                 w_accept;

    assign w_last_stop = (r_state == ST_STOP) && (r_stop_cnt == 1'(STOP_BITS - 1));
    assign tx_ready    = !r_pending && ((r_state == ST_IDLE) || w_last_stop);
    assign w_accept    = tx_valid && tx_ready;
    assign tx          = r_tx;
    assign busy        = (r_state != ST_IDLE) || r_pending;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_pending  <= 1'b0;
            r_parity   <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_stop_cnt <= w_stop_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_parity   <= w_parity_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_stop_cnt_nxt = r_stop_cnt;
        w_pending_nxt  = r_pending;
        w_parity_nxt   = r_parity;
        w_tx_nxt       = r_tx;

        // Acceptance is only possible in IDLE or the last stop bit, so the
        // shift register is never in use when it is reloaded here.
        if (w_accept) begin
            w_shift_nxt   = tx_data;
            w_parity_nxt  = (^tx_data) ^ 1'(PARITY_ODD);
            w_pending_nxt = 1'b1;
        end

        if (tick_baud) begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pending) begin
                        w_tx_nxt      = 1'b0;
                        w_pending_nxt = 1'b0;
                        w_state_nxt   = ST_START;
                    end
                end
                ST_START: begin
                    w_tx_nxt      = r_shift[0];
                    w_shift_nxt   = r_shift >> 1;
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = ST_DATA;
                end
                ST_DATA: begin
                    if (r_bit_cnt == 4'(DATA_BITS - 1)) begin
                        if (PARITY_EN != 0) begin
                            w_tx_nxt    = r_parity;
                            w_state_nxt = ST_PARITY;
                        end else begin
                            w_tx_nxt       = 1'b1;
                            w_stop_cnt_nxt = 1'b0;
                            w_state_nxt    = ST_STOP;
                        end
                    end else begin
                        w_tx_nxt      = r_shift[0];
                        w_shift_nxt   = r_shift >> 1;
                        w_bit_cnt_nxt = r_bit_cnt + 4'd1;
                    end
                end
                ST_PARITY: begin
                    w_tx_nxt       = 1'b1;
                    w_stop_cnt_nxt = 1'b0;
                    w_state_nxt    = ST_STOP;
                end
                ST_STOP: begin
                    if (!w_last_stop) begin
                        w_stop_cnt_nxt = r_stop_cnt + 1'b1;
                    end else if (r_pending || w_accept) begin
                        // Byte taken on this edge or earlier: start bit follows with no gap.
                        w_tx_nxt      = 1'b0;
                        w_pending_nxt = 1'b0;
                        w_state_nxt   = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: begin
                    w_tx_nxt    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances (8N1 at DIV=868, 8E1, 8O1
// and 8N2 at DIV=16) checked bit by bit against hand-computed frames.
module tb_uart_tx_ctrl;

    localparam int DIV_A = 868;
    localparam int DIV_B = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_mid = 1'b0;
    logic       force_tick = 1'b1;
    logic       tgl = 1'b0;
    int         c_a = 0;
    int         c_b = 0;
    logic       tick_a, tick_b;
    logic [3:0] v_valid = 4'b0;
    logic [7:0] v_data [4];
    logic [3:0] w_tx, w_rdy, w_busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Free-running baud strobes; while force_tick is set they toggle every cycle.
    always @(posedge clk) begin
        c_a <= (c_a == DIV_A - 1) ? 0 : c_a + 1;
        c_b <= (c_b == DIV_B - 1) ? 0 : c_b + 1;
        tgl <= ~tgl;
    end
    assign tick_a = force_tick ? tgl : (c_a == DIV_A - 1);
    assign tick_b = force_tick ? tgl : (c_b == DIV_B - 1);

    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst | rst_mid), .tick_baud(tick_a), .tx_data(v_data[0]),
        .tx_valid(v_valid[0]), .tx_ready(w_rdy[0]), .tx(w_tx[0]), .busy(w_busy[0]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .tick_baud(tick_b), .tx_data(v_data[1]),
        .tx_valid(v_valid[1]), .tx_ready(w_rdy[1]), .tx(w_tx[1]), .busy(w_busy[1]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .tick_baud(tick_b), .tx_data(v_data[2]),
        .tx_valid(v_valid[2]), .tx_ready(w_rdy[2]), .tx(w_tx[2]), .busy(w_busy[2]));
    uart_tx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .rst(rst), .tick_baud(tick_b), .tx_data(v_data[3]),
        .tx_valid(v_valid[3]), .tx_ready(w_rdy[3]), .tx(w_tx[3]), .busy(w_busy[3]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int w, input logic [7:0] d);
        int n = 0;
        while (w_rdy[w] !== 1'b1 && n < 20 * DIV_A) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("send%0d_ready", w), 32'(w_rdy[w]), 32'd1);
        v_data[w]  = d;
        v_valid[w] = 1'b1;
        @(negedge clk);
        v_valid[w] = 1'b0;
    endtask

    // Waits for the start-bit falling edge, then checks the first and last
    // cycle of every bit, so each bit must last exactly div cycles.
    task automatic capture(input int w, input int div, input int nbits,
                           input logic [31:0] expv, input string tag);
        int   n = 0;
        logic prev;
        prev = w_tx[w];
        forever begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && w_tx[w] === 1'b0) break;
            prev = w_tx[w];
            if (n > 4 * div + 10) begin
                check({tag, "_start_timeout"}, 32'd0, 32'd1);
                return;
            end
        end
        for (int k = 0; k < nbits; k++) begin
            check($sformatf("%s_b%0d_first", tag, k), 32'(w_tx[w]), 32'(expv[k]));
            repeat (div - 1) @(negedge clk);
            check($sformatf("%s_b%0d_last", tag, k), 32'(w_tx[w]), 32'(expv[k]));
            if (k != nbits - 1) @(negedge clk);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) v_data[i] = 8'h00;

        // Reset held 5 cycles with ticks toggling
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int w = 0; w < 4; w++) begin
                check($sformatf("rst_c%0d_tx%0d", c, w), 32'(w_tx[w]), 32'd1);
                check($sformatf("rst_c%0d_rdy%0d", c, w), 32'(w_rdy[w]), 32'd1);
                check($sformatf("rst_c%0d_busy%0d", c, w), 32'(w_busy[w]), 32'd0);
            end
        end
        rst        = 1'b0;
        force_tick = 1'b0;
        repeat (3) @(negedge clk);
        for (int w = 0; w < 4; w++) begin
            check($sformatf("post_rst_tx%0d", w), 32'(w_tx[w]), 32'd1);
            check($sformatf("post_rst_rdy%0d", w), 32'(w_rdy[w]), 32'd1);
            check($sformatf("post_rst_busy%0d", w), 32'(w_busy[w]), 32'd0);
        end

        // 8N1 0xA5: line 0,1,0,1,0,0,1,0,1 then stop
        send(0, 8'hA5);
        check("a5_busy_pend", 32'(w_busy[0]), 32'd1);
        check("a5_rdy_pend", 32'(w_rdy[0]), 32'd0);
        capture(0, DIV_A, 9, 32'h14A, "a5");
        @(negedge clk);
        check("a5_stop_first", 32'(w_tx[0]), 32'd1);
        check("a5_stop_rdy", 32'(w_rdy[0]), 32'd1);
        check("a5_stop_busy", 32'(w_busy[0]), 32'd1);
        repeat (DIV_A - 1) @(negedge clk);
        check("a5_stop_last", 32'(w_tx[0]), 32'd1);
        check("a5_stop_last_busy", 32'(w_busy[0]), 32'd1);
        @(negedge clk);
        check("a5_idle_busy", 32'(w_busy[0]), 32'd0);
        check("a5_idle_rdy", 32'(w_rdy[0]), 32'd1);
        check("a5_idle_tx", 32'(w_tx[0]), 32'd1);

        // Back-to-back 0x00 then 0xFF, valid held: 20 contiguous bits
        repeat (5) @(negedge clk);
        fork
            capture(0, DIV_A, 20, 32'h000FFA00, "b2b");
            begin
                int n = 0;
                v_data[0]  = 8'h00;
                v_valid[0] = 1'b1;
                @(negedge clk);
                v_data[0] = 8'hFF;
                while (w_rdy[0] !== 1'b1 && n < 12 * DIV_A) begin
                    @(negedge clk);
                    n++;
                end
                check("b2b_second_ready", 32'(w_rdy[0]), 32'd1);
                check("b2b_ready_in_stop", 32'(w_tx[0]), 32'd1);
                @(negedge clk);
                v_valid[0] = 1'b0;
                check("b2b_pend_busy", 32'(w_busy[0]), 32'd1);
                check("b2b_pend_rdy", 32'(w_rdy[0]), 32'd0);
            end
        join
        @(negedge clk);
        check("b2b_idle_busy", 32'(w_busy[0]), 32'd0);

        // Reset during data bit 3 of 0x55, then 0x3C from a clean start
        repeat (5) @(negedge clk);
        send(0, 8'h55);
        capture(0, DIV_A, 4, 32'h0000000A, "mid");
        @(negedge clk);
        check("mid_d3", 32'(w_tx[0]), 32'd0);
        repeat (100) @(negedge clk);
        rst_mid = 1'b1;
        @(negedge clk);
        rst_mid = 1'b0;
        check("mid_rst_tx", 32'(w_tx[0]), 32'd1);
        check("mid_rst_rdy", 32'(w_rdy[0]), 32'd1);
        check("mid_rst_busy", 32'(w_busy[0]), 32'd0);
        send(0, 8'h3C);
        capture(0, DIV_A, 10, 32'h00000278, "c3");
        @(negedge clk);
        check("c3_idle_busy", 32'(w_busy[0]), 32'd0);

        // 0x07 with even (parity 1) and odd (parity 0): 11-tick frames
        fork
            begin
                send(1, 8'h07);
                capture(1, DIV_B, 11, 32'h0000060E, "even");
            end
            begin
                send(2, 8'h07);
                capture(2, DIV_B, 11, 32'h0000040E, "odd");
            end
        join
        @(negedge clk);
        check("even_idle_busy", 32'(w_busy[1]), 32'd0);
        check("odd_idle_busy", 32'(w_busy[2]), 32'd0);

        // 8N2 0x5A with valid pulses and data toggles while not ready
        fork
            capture(3, DIV_B, 12, 32'h00000EB4, "s2");
            begin
                send(3, 8'h5A);
                for (int p = 0; p < 4; p++) begin
                    check($sformatf("s2_ign%0d_rdy", p), 32'(w_rdy[3]), 32'd0);
                    v_data[3]  = 8'hC3 ^ 8'(p);
                    v_valid[3] = 1'b1;
                    @(negedge clk);
                    v_valid[3] = 1'b0;
                    v_data[3]  = ~v_data[3];
                    repeat (20) @(negedge clk);
                end
            end
        join
        @(negedge clk);
        check("s2_idle_busy", 32'(w_busy[3]), 32'd0);
        repeat (3 * DIV_B) @(negedge clk);
        check("s2_no_extra_frame", 32'(w_tx[3]), 32'd1);
        check("s2_still_idle", 32'(w_busy[3]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
UART transmit sequencer. It consumes the single-cycle `tick_baud` strobe from `baud_gen` and frames parallel bytes onto the serial line: start bit, LSB-first data, optional parity, stop bit(s). Upstream logic loads bytes through a valid/ready handshake. A one-deep pending slot allows back-to-back frames with no idle gap. Sits between the transmit byte source and the `tx` pad, alongside `baud_gen`.

Parameters:
- DATA_BITS, 8: data bits per frame; legal range 5..9.
- PARITY_EN, 0: 1 appends a parity bit after the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd; ignored when PARITY_EN=0.
- STOP_BITS, 1: number of stop bits; legal values 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick_baud  in  1  one-cycle bit-period strobe from baud_gen
- tx_data  in  DATA_BITS  byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  controller can accept a byte this cycle
- tx  out  1  serial line, registered, idle high
- busy  out  1  frame in progress or byte pending

Behaviour:
- Reset (clk edge with rst=1): tx=1, tx_ready=1, busy=0, state=IDLE, pending=0, counters=0. tick_baud is ignored while rst=1. Reset mid-frame aborts the frame immediately; tx returns to 1 at that edge.
- Handshake:
  - Transfer occurs when tx_valid && tx_ready at a posedge; tx_data is latched into the shift register and pending is set to 1.
  - tx_data and tx_valid are ignored while tx_ready=0.
  - tx_ready = !pending && (state==IDLE || (state==STOP && stop_cnt==STOP_BITS-1)). It is combinational from registered state.
- States: IDLE, START, DATA, PARITY, STOP. All bit transitions occur only on edges where tick_baud=1, so every bit is held exactly one tick interval.
  - IDLE: tx=1. On a tick with pending=1: tx<=0, pending<=0, go to START.
  - START: on tick, tx<=shift[0], shift right, bit_cnt<=0, go to DATA.
  - DATA: on tick with bit_cnt<DATA_BITS-1, tx<=next bit and bit_cnt++. On tick with bit_cnt==DATA_BITS-1:
    - if PARITY_EN: tx<=parity, go to PARITY;
    - otherwise: tx<=1, stop_cnt<=0, go to STOP.
  - PARITY: on tick, tx<=1, stop_cnt<=0, go to STOP.
  - STOP: on tick with stop_cnt<STOP_BITS-1, stop_cnt++ (tx stays 1). On the final stop tick:
    - if pending: tx<=0, pending<=0, go to START (zero-gap back-to-back);
    - otherwise: go to IDLE.
- Parity is computed over the latched data bits: even = XOR of the bits; odd = ~XOR. It is computed at load time and held.
- Latency: the start bit begins at the first tick after acceptance. The IDLE wait is therefore 1..DIV cycles, depending on tick phase.
- busy = (state != IDLE) || pending.
- Simultaneous events: acceptance and the final stop tick on the same edge means the new byte is loaded and the start bit is driven on that edge. A tick on the acceptance edge while in IDLE does not start the frame; the frame waits for the next tick.
- Frame length in ticks: 1 + DATA_BITS + PARITY_EN + STOP_BITS.

Test Plan:
- Reset: assert rst for 5 cycles with tick_baud toggling -> tx=1, tx_ready=1, busy=0 throughout and after release.
- Single frame, 8N1, real baud_gen (CLK_FREQ=100000000, BAUD_RATE=115200, DIV=868), send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1. Each bit lasts exactly 868 cycles. busy drops at the final stop tick; tx_ready reasserts in the last stop interval.
- Back-to-back, tx_valid held high with 0x00 then 0xFF -> second byte accepted during frame 1's stop bit. Start bit of frame 2 follows the stop bit directly, with no extra idle interval (stop high for exactly 868 cycles).
- Parity, DATA_BITS=8, PARITY_EN=1, send 0x07:
  - PARITY_ODD=0 -> parity bit 1;
  - PARITY_ODD=1 -> parity bit 0.
  - Frame is 11 ticks long in both cases.
- Reset mid-frame during data bit 3 -> tx=1 at the reset edge, tx_ready=1, pending cleared. The next byte 0x3C is sent correctly from a fresh start bit.
- STOP_BITS=2; while busy and tx_ready=0, toggle tx_data and pulse tx_valid -> neither is accepted, and the line carries only the originally accepted byte. The stop level is high for 2 tick intervals.
